// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Sequencing controller for the multicycle CPU datapath. Every instruction
// passes through fetch and decode. It then runs execute, memory and
// write-back states as its opcode requires. Illegal opcodes park the
// machine in HALT until reset.
//
// Ports:
//   clk, reset        system clock; synchronous active-high reset
//   opcode[3:0]       IR[15:12]; only decoded during DECODE
//   zero              ALU zero flag (branch decision)
//   mem_ready         memory has completed the current access
//   mem_read/write    memory request strobes
//   ir_write, pc_write, reg_write   register enables
//   i_or_d, alu_src_a, alu_src_b, pc_source, reg_dst, mem_to_reg   mux selects
//   rtype, beq        qualifiers for ALU_Control_Unit
//   illegal_op        sticky illegal-opcode flag
//   instr_count       retired-instruction counter (wraps)
//   state             current state encoding, for debug
module multicycle_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             i_or_d,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             rtype,
  output logic             beq,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_ALU_WB   = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_EXEC_I   = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd15;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_JUMP  = 4'b0101;

  logic [3:0]       state_r;
  logic [3:0]       state_next_s;
  logic [3:0]       opc_r;
  logic             illegal_r;
  logic             illegal_dec_s;
  logic             retire_s;
  logic [CNT_W-1:0] count_r;

  // State register, latched opcode, sticky illegal flag and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_FETCH;
      opc_r     <= 4'd0;
      illegal_r <= 1'b0;
      count_r   <= '0;
    end else begin
      state_r <= state_next_s;
      // Later states must see the opcode as decoded, not the live IR field
      if (state_r == S_DECODE) begin
        opc_r <= opcode;
      end
      if (illegal_dec_s) begin
        illegal_r <= 1'b1;
      end
      if (retire_s) begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

  // Next-state logic, illegal-opcode detection and retire strobe
  always_comb begin
    state_next_s  = state_r;
    illegal_dec_s = 1'b0;
    retire_s      = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) begin
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_next_s = S_EXEC_R;
          OP_ADDI:       state_next_s = S_EXEC_I;
          OP_LW, OP_SW:  state_next_s = S_MEM_ADDR;
          OP_BEQ:        state_next_s = S_BRANCH;
          OP_JUMP:       state_next_s = S_JUMP;
          default: begin
            state_next_s  = S_HALT;
            illegal_dec_s = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        if (opc_r == OP_LW) begin
          state_next_s = S_MEM_RD;
        end else begin
          state_next_s = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        if (mem_ready) begin
          state_next_s = S_MEM_WB;
        end else begin
          state_next_s = S_MEM_RD;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_next_s = S_FETCH;
          retire_s     = 1'b1;
        end else begin
          state_next_s = S_MEM_WR;
        end
      end
      S_EXEC_R, S_EXEC_I: state_next_s = S_ALU_WB;
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: begin
        state_next_s = S_FETCH;
        retire_s     = 1'b1;
      end
      S_HALT:  state_next_s = S_HALT;
      default: state_next_s = S_HALT;
    endcase
  end

  // Datapath controls decoded from the current state (fetch enables are Mealy on mem_ready)
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    i_or_d     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    rtype      = 1'b0;
    beq        = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEM_ADDR, S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        rtype     = 1'b1;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (opc_r == OP_RTYPE);
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        beq       = 1'b1;
        pc_source = 2'b01;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: begin
        mem_read = 1'b0;
      end
    endcase
  end

  assign illegal_op  = illegal_r;
  assign instr_count = count_r;
  assign state       = state_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [3:0] opcode;
  logic mem_read, mem_write, ir_write, pc_write, reg_write, i_or_d, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic reg_dst, mem_to_reg, rtype, beq, illegal_op;
  logic [15:0] instr_count;
  logic [3:0] state;
  // Narrow-counter instance sharing the same stimulus
  logic m4_mr, m4_mw, m4_irw, m4_pcw, m4_rw, m4_iod, m4_asa, m4_rd, m4_m2r, m4_rt, m4_bq, m4_ill;
  logic [1:0] m4_asb, m4_pcs;
  logic [3:0] instr_count4, state4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .i_or_d(i_or_d), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .rtype(rtype),
    .beq(beq), .illegal_op(illegal_op), .instr_count(instr_count), .state(state));

  multicycle_control_fsm #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(m4_mr), .mem_write(m4_mw), .ir_write(m4_irw), .pc_write(m4_pcw),
    .reg_write(m4_rw), .i_or_d(m4_iod), .alu_src_a(m4_asa), .alu_src_b(m4_asb),
    .pc_source(m4_pcs), .reg_dst(m4_rd), .mem_to_reg(m4_m2r), .rtype(m4_rt),
    .beq(m4_bq), .illegal_op(m4_ill), .instr_count(instr_count4), .state(state4));

  typedef struct {
    int         st;
    logic       rdy;
    logic       z;
    logic [3:0] opc;
  } cyc_t;

  typedef struct {
    logic [3:0] op;
    logic       z;
    int         fw;
    int         dw;
    int         lat;
  } vec_t;

  cyc_t plan[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output vector: {illegal, mem_read, mem_write, ir_write, pc_write, reg_write, i_or_d,
  //                 alu_src_a, alu_src_b[2], pc_source[2], reg_dst, mem_to_reg, rtype, beq}
  function automatic logic [15:0] outv();
    return {illegal_op, mem_read, mem_write, ir_write, pc_write, reg_write, i_or_d, alu_src_a,
            alu_src_b, pc_source, reg_dst, mem_to_reg, rtype, beq};
  endfunction

  function automatic logic [15:0] outv4();
    return {m4_ill, m4_mr, m4_mw, m4_irw, m4_pcw, m4_rw, m4_iod, m4_asa,
            m4_asb, m4_pcs, m4_rd, m4_m2r, m4_rt, m4_bq};
  endfunction

  // Expected controls for a named state, straight from the state descriptions
  function automatic logic [15:0] exp_out(input int st, input logic rdy, input logic z,
                                          input logic [3:0] op);
    logic ill, mr, mw, irw, pcw, rw, iod, asa, rd, m2r, rt, bq;
    logic [1:0] asb, pcs;
    {ill, mr, mw, irw, pcw, rw, iod, asa, rd, m2r, rt, bq} = 12'b0;
    asb = 2'b00;
    pcs = 2'b00;
    case (st)
      0:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  begin mr = 1'b1; iod = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mw = 1'b1; iod = 1'b1; end
      6:  begin asa = 1'b1; rt = 1'b1; end
      7:  begin rw = 1'b1; rd = (op == 4'b0000); end
      8:  begin asa = 1'b1; bq = 1'b1; pcs = 2'b01; pcw = z; end
      9:  begin pcw = 1'b1; pcs = 2'b10; end
      10: begin asa = 1'b1; asb = 2'b10; end
      15: ill = 1'b1;
      default: ill = 1'b0;
    endcase
    return {ill, mr, mw, irw, pcw, rw, iod, asa, asb, pcs, rd, m2r, rt, bq};
  endfunction

  // Zero-wait latency of each legal opcode
  function automatic int lat_of(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd3: return 4;
      4'd2:             return 5;
      default:          return 3;
    endcase
  endfunction

  function automatic cyc_t mk(input int st, input logic rdy, input logic z, input logic [3:0] opc);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.z = z; c.opc = opc;
    return c;
  endfunction

  // Cycle-by-cycle plan: state visited and stimulus to apply. Live opcode and
  // don't-care inputs are scrambled outside FETCH/DECODE.
  task automatic build_plan(input logic [3:0] op, input logic z, input int fw, input int dw);
    plan.delete();
    for (int k = 0; k < fw; k++) plan.push_back(mk(0, 1'b0, 1'($urandom), op));
    plan.push_back(mk(0, 1'b1, 1'($urandom), op));
    plan.push_back(mk(1, 1'($urandom), 1'($urandom), op));
    case (op)
      4'd0: begin
        plan.push_back(mk(6, 1'($urandom), 1'($urandom), 4'($urandom)));
        plan.push_back(mk(7, 1'($urandom), 1'($urandom), 4'($urandom)));
      end
      4'd1: begin
        plan.push_back(mk(10, 1'($urandom), 1'($urandom), 4'($urandom)));
        plan.push_back(mk(7, 1'($urandom), 1'($urandom), 4'($urandom)));
      end
      4'd2, 4'd3: begin
        plan.push_back(mk(2, 1'($urandom), 1'($urandom), 4'($urandom)));
        for (int k = 0; k < dw; k++)
          plan.push_back(mk((op == 4'd2) ? 3 : 5, 1'b0, 1'($urandom), 4'($urandom)));
        plan.push_back(mk((op == 4'd2) ? 3 : 5, 1'b1, 1'($urandom), 4'($urandom)));
        if (op == 4'd2) plan.push_back(mk(4, 1'($urandom), 1'($urandom), 4'($urandom)));
      end
      4'd4:    plan.push_back(mk(8, 1'($urandom), z, 4'($urandom)));
      default: plan.push_back(mk(9, 1'($urandom), 1'($urandom), 4'($urandom)));
    endcase
  endtask

  // Runs one instruction, checking state and controls each cycle; returns the
  // cycle count until the DUT re-enters FETCH
  task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int dw,
                           output int cyc);
    int i;
    bit left;
    logic [15:0] c0;
    logic [3:0] c4;
    build_plan(op, z, fw, dw);
    c0 = instr_count;
    c4 = instr_count4;
    i = 0;
    left = 1'b0;
    forever begin
      if (i < plan.size()) begin
        opcode = plan[i].opc; zero = plan[i].z; mem_ready = plan[i].rdy;
      end else begin
        mem_ready = 1'b1;
      end
      #2;
      if (left && state == 4'd0) break;
      if (state != 4'd0) left = 1'b1;
      if (i < plan.size()) begin
        chk("state", 32'(state), 32'(plan[i].st));
        chk("state4", 32'(state4), 32'(plan[i].st));
        chk("outputs", 32'(outv()), 32'(exp_out(plan[i].st, plan[i].rdy, plan[i].z, op)));
        chk("outputs4", 32'(outv4()), 32'(exp_out(plan[i].st, plan[i].rdy, plan[i].z, op)));
        chk("count_hold", 32'(instr_count), 32'(c0));
      end else begin
        chk("overrun_state", 32'(state), 32'd0);
      end
      i++;
      if (i > 40) begin
        n_chk++;
        n_fail++;
        $display("FAIL timeout: op %0d did not return to FETCH within 40 cycles", op);
        break;
      end
      tick();
    end
    cyc = i;
    chk("count_retire", 32'(instr_count), 32'(16'(c0 + 16'd1)));
    chk("count4_retire", 32'(instr_count4), 32'(4'(c4 + 4'd1)));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    int cyc;
    logic [3:0] op;
    logic z;
    int fw, dw;
    logic [15:0] c0;

    vecs[0] = '{4'd0, 1'b0, 0, 0, 4};
    vecs[1] = '{4'd1, 1'b0, 0, 0, 4};
    vecs[2] = '{4'd2, 1'b0, 0, 0, 5};
    vecs[3] = '{4'd3, 1'b0, 0, 0, 4};
    vecs[4] = '{4'd4, 1'b1, 0, 0, 3};
    vecs[5] = '{4'd4, 1'b0, 0, 0, 3};
    vecs[6] = '{4'd5, 1'b0, 0, 0, 3};
    vecs[7] = '{4'd2, 1'b0, 0, 3, 8};
    vecs[8] = '{4'd3, 1'b0, 1, 2, 7};
    vecs[9] = '{4'd0, 1'b0, 2, 0, 6};

    reset = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;
    do_reset();

    // Reset state, both polarities of the fetch handshake
    #2;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_out_wait", 32'(outv()), 32'(16'b0100_0000_0100_0000));
    mem_ready = 1'b1;
    #1;
    chk("rst_out_ready", 32'(outv()), 32'(16'b0101_1000_0100_0000));

    // Directed table
    foreach (vecs[k]) begin
      run_instr(vecs[k].op, vecs[k].z, vecs[k].fw, vecs[k].dw, cyc);
      chk($sformatf("latency_vec%0d", k), 32'(cyc), 32'(vecs[k].lat));
    end

    // Randomized instruction stream against the latency model
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 5));
      z  = 1'($urandom);
      fw = $urandom_range(0, 2);
      dw = (op == 4'd2 || op == 4'd3) ? $urandom_range(0, 3) : 0;
      run_instr(op, z, fw, dw, cyc);
      chk("latency_rand", 32'(cyc), 32'(lat_of(op) + fw + dw));
    end

    // Reset during the sw data wait: transfer completes under reset but is not counted
    do_reset();
    opcode = 4'd3; mem_ready = 1'b1;
    tick();
    tick();
    opcode = 4'd0;
    tick();
    mem_ready = 1'b0;
    #2;
    chk("sw_wait_state", 32'(state), 32'd5);
    chk("sw_wait_strobe", 32'(mem_write), 32'd1);
    tick();
    #2;
    chk("sw_wait_hold", 32'(mem_write), 32'd1);
    reset = 1'b1; mem_ready = 1'b1;
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    #2;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_count", 32'(instr_count), 32'd0);

    // Illegal opcode parks in HALT; inputs are ignored there
    run_instr(4'd5, 1'b0, 0, 0, cyc);
    c0 = instr_count;
    opcode = 4'hF; mem_ready = 1'b1;
    tick();
    tick();
    for (int n = 0; n < 12; n++) begin
      opcode = 4'($urandom); mem_ready = 1'($urandom); zero = 1'($urandom);
      #2;
      chk("halt_state", 32'(state), 32'd15);
      chk("halt_outputs", 32'(outv()), 32'(16'h8000));
      chk("halt_count", 32'(instr_count), 32'(c0));
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    #2;
    chk("halt_rst_state", 32'(state), 32'd0);
    chk("halt_rst_illegal", 32'(illegal_op), 32'd0);

    // 16 jumps: narrow counter wraps 15 -> 0
    do_reset();
    for (int n = 0; n < 16; n++) begin
      run_instr(4'd5, 1'b0, 0, 0, cyc);
      if (n == 14) chk("wrap_15", 32'(instr_count4), 32'd15);
    end
    chk("wrap_0", 32'(instr_count4), 32'd0);
    chk("wide_16", 32'(instr_count), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main sequencing controller for the multicycle CPU datapath. Decodes the 4-bit instruction opcode and steps each instruction through fetch, decode, execute, memory and write-back states. Drives the datapath enables and muxes, plus the `rtype`/`beq` qualifiers consumed by `ALU_Control_Unit`. Handshakes with a variable-latency memory and counts retired instructions.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk`  in  1  single system clock; everything samples on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  4  instruction opcode, taken from IR[15:12].
  - 0000 R-type; 0001 addi; 0010 lw; 0011 sw; 0100 beq; 0101 jump; all others are illegal.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current access.
- `mem_read`, `mem_write`  out  1  memory request strobes.
- `ir_write`, `pc_write`, `reg_write`  out  1  register enables.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `alu_src_a`  out  1  ALU A operand select: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B operand select: 00 = register B, 01 = constant 1, 10 = sign-extended immediate, 11 = sign-extended immediate << 1.
- `pc_source`  out  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `reg_dst`  out  1  destination register select: 1 = rd, 0 = rt.
- `mem_to_reg`  out  1  write-back data select: 1 = MDR, 0 = ALUOut.
- `rtype`, `beq`  out  1  qualifiers for `ALU_Control_Unit`.
- `illegal_op`  out  1  sticky flag: an illegal opcode was decoded.
- `instr_count`  out  CNT_W  number of retired instructions.
- `state`  out  4  current state encoding, for debug.

## Operation
- State encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5.
  - EXEC_R=6, ALU_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, HALT=15.
- Any output not listed for a state is 0.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, pc_source=00.
  - Asserts ir_write and pc_write only while mem_ready=1; these two outputs are Mealy on mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11 to precompute the branch target.
  - Next state by opcode: 0000→EXEC_R; 0001→EXEC_I; 0010/0011→MEM_ADDR; 0100→BRANCH; 0101→JUMP; any other→HALT, which sets illegal_op.
- EXEC_R: alu_src_a=1, alu_src_b=00, rtype=1; goes to ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=10; goes to ALU_WB.
- ALU_WB:
  - reg_write=1, mem_to_reg=0.
  - reg_dst=1 if the latched opcode is R-type, else 0.
  - Goes to FETCH and retires the instruction.
- MEM_ADDR: alu_src_a=1, alu_src_b=10; goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1; holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; goes to FETCH and retires.
- MEM_WR: mem_write=1, i_or_d=1; holds until mem_ready, then goes to FETCH and retires.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, beq=1, pc_source=01.
  - pc_write=zero.
  - Goes to FETCH and retires whether or not the branch is taken.
- JUMP: pc_write=1, pc_source=10; goes to FETCH and retires.
- HALT:
  - All enables and strobes are 0; the FSM stays in HALT until reset.
  - illegal_op=1.
- Opcode latching: the opcode is latched into an internal register on the DECODE cycle. Later states use the latched copy, never the live `opcode`.
- rtype and beq are never asserted together.

## Timing
- On reset:
  - state=FETCH, illegal_op=0, instr_count=0, latched opcode=0.
  - All outputs take their FETCH values: mem_read=1, alu_src_b=01, everything else 0 unless mem_ready=1.
- reset takes priority over every transition, including mid-instruction and during a memory wait. The aborted instruction is not counted.
- Latency with zero-wait memory (mem_ready=1 whenever sampled), in cycles from FETCH to FETCH:
  - beq 3, jump 3, R-type 4, addi 4, sw 4, lw 5.
- Each wait cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- Memory handshake:
  - mem_read/mem_write stay stable while waiting.
  - A transfer completes in any cycle where strobe && mem_ready.
  - mem_ready sampled while no strobe is asserted is ignored.
- instr_count increments by 1 on the final cycle of each retired instruction. It wraps from 2^CNT_W−1 to 0 and never increments in HALT.

## Test plan
- Reset, then hold mem_ready=1 with opcode=0000:
  - States go 0,1,6,7,0.
  - rtype=1 only in state 6; reg_write=1 and reg_dst=1 in state 7.
  - instr_count=1 after the fourth cycle.
- lw with mem_ready low for 3 cycles in MEM_RD:
  - States go 0,1,2,3,3,3,3,4,0.
  - mem_read held for 4 cycles; mem_to_reg=1 in state 4.
- beq:
  - zero=1 → pc_write=1 with pc_source=01 in BRANCH.
  - zero=0 → pc_write=0.
  - beq=1 in BRANCH only; both cases take 3 cycles.
- opcode=1111 → HALT:
  - illegal_op=1; all enables 0 for 10+ cycles; instr_count frozen.
  - reset → state 0, illegal_op=0.
- Assert reset during the MEM_WR wait → next cycle state=0, mem_write=0, instr_count unchanged.
- CNT_W=4, run 16 jumps → instr_count wraps 15→0.
